instruction_fetch: RTL



---
 rtl/instruction_fetch_pkg.sv | 19 +
 rtl/fetch_skid_buffer.sv | 25 ++
 rtl/instruction_fetch.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared constants and types for the fetch stage
// Purpose: NOP encoding, fetch exception cause and fetch FSM state type.
// Ports: none (package).
package instruction_fetch_pkg;

  // addi x0, x0, 0 -- the bubble pushed into IF_ID when no instruction is ready
  localparam logic [31:0] NOP = 32'h0000_0013;

  // ExceptionDefines: instruction-address-misaligned cause code
  localparam logic [3:0] EXCEPTION_INST_MISALIGNED = 4'd0;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    HOLD       = 2'd1,
    DISCARD    = 2'd2,
    IDLE_FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - single-entry instruction skid buffer
// Purpose: parks one fetched word while the pipeline is stalled.
// Ports: clk, rst (sync, active-high), load/load_data capture a word,
//        clear empties the entry (wins over load), valid/data expose it.
module fetch_skid_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_data,
  output logic        valid,
  output logic [31:0] data
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      data  <= 32'h0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RISC-V fetch stage: PC, instruction bus, IF_ID register
// Purpose: owns the PC, issues one-outstanding fetches, fills IF_ID, handles
//          stalls, redirects and instruction-address-misaligned faults.
// Ports: clk, rst (sync, active-high); stall_if holds IF_ID/PC; jump_en/jump_addr
//        redirect; ibus_req/ibus_addr/ibus_rvalid/ibus_rdata instruction bus;
//        instruction_addr_if_id/instruction_if_id IF_ID register;
//        exception_if/exception_cause_if misaligned fault flag and cause.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] instruction_addr_if_id,
  output logic [31:0] instruction_if_id,
  output logic        exception_if,
  output logic [3:0]  exception_cause_if
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  if_addr_q, if_addr_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic         exc_q, exc_d;

  logic         skid_load, skid_clear, skid_valid;
  logic [31:0]  skid_data;
  logic         accept;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (ibus_rdata),
    .valid     (skid_valid),
    .data      (skid_data)
  );

  assign accept   = req_q && ibus_rvalid;
  assign target   = jump_addr & ~32'h1;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    if_addr_d  = if_addr_q;
    if_instr_d = if_instr_q;
    exc_d      = exc_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (jump_en) begin
      skid_clear = 1'b1;
      if_instr_d = NOP;
      exc_d      = 1'b0;
      pc_d       = target;
      if (req_q && !ibus_rvalid) begin
        // bus address must stay put until the in-flight word returns
        state_d = DISCARD;
      end else if (target[1]) begin
        state_d   = IDLE_FAULT;
        req_d     = 1'b0;
        if_addr_d = target;
        exc_d     = 1'b1;
      end else begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = target;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (accept) begin
            if (stall_if) begin
              skid_load = 1'b1;
              state_d   = HOLD;
              req_d     = 1'b0;
            end else begin
              if_addr_d  = pc_q;
              if_instr_d = ibus_rdata;
              exc_d      = 1'b0;
              pc_d       = pc_plus4;
              addr_d     = pc_plus4;
              req_d      = 1'b1;
            end
          end else begin
            // only true right after reset: launch the first request
            if (!req_q) begin
              req_d  = 1'b1;
              addr_d = pc_q;
            end
            if (!stall_if) begin
              if_instr_d = NOP;
              exc_d      = 1'b0;
            end
          end
        end
        HOLD: begin
          if (!stall_if && skid_valid) begin
            if_addr_d  = pc_q;
            if_instr_d = skid_data;
            exc_d      = 1'b0;
            pc_d       = pc_plus4;
            addr_d     = pc_plus4;
            req_d      = 1'b1;
            skid_clear = 1'b1;
            state_d    = FETCH;
          end
        end
        DISCARD: begin
          if (!stall_if) begin
            if_instr_d = NOP;
            exc_d      = 1'b0;
          end
          if (accept) begin
            if (pc_q[1]) begin
              // misaligned target: fault entry is loaded by IDLE_FAULT
              state_d = IDLE_FAULT;
              req_d   = 1'b0;
            end else begin
              state_d = FETCH;
              req_d   = 1'b1;
              addr_d  = pc_q;
            end
          end
        end
        IDLE_FAULT: begin
          // idempotent reload; pc_q holds the faulting target
          if (!stall_if) begin
            if_addr_d  = pc_q;
            if_instr_d = NOP;
            exc_d      = 1'b1;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      if_addr_q  <= 32'h0;
      if_instr_q <= NOP;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      if_addr_q  <= if_addr_d;
      if_instr_q <= if_instr_d;
      exc_q      <= exc_d;
    end
  end

  assign ibus_req               = req_q;
  assign ibus_addr              = addr_q;
  assign instruction_addr_if_id = if_addr_q;
  assign instruction_if_id      = if_instr_q;
  assign exception_if           = exc_q;
  assign exception_cause_if     = EXCEPTION_INST_MISALIGNED;

endmodule
